// File: rtl/alu_exec_stage_if.sv
// Request/response bundle for the ALU execute stage.
// Master drives requests and the result-accept strobe; slave is the stage itself.
interface alu_exec_stage_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [3:0]       out_flags;
  logic             out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_y, out_flags, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_y, out_flags, out_err
  );
endinterface

// File: rtl/alu_exec_stage.sv
// Two-register 32-bit ALU execute stage: S1 captures the request, S2 holds result + {N,Z,C,V}.
// Bitwise OR is delegated to the shared orrs_32bit unit.
module orrs_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = a | b;
endmodule

module alu_exec_stage #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_exec_stage_if.slave     bus,
  output logic [15:0]         op_count
);
  localparam logic [3:0] OP_AND = 4'd0, OP_OR  = 4'd1, OP_XOR = 4'd2,
                         OP_ADD = 4'd3, OP_SUB = 4'd4, OP_SLT = 4'd5,
                         OP_SLL = 4'd6, OP_SRL = 4'd7, OP_SRA = 4'd8;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [3:0]       flags;
    logic             err;
  } rsp_t;

  req_t             s1_q;
  logic             s1_valid;
  rsp_t             s2_q, s2_d;
  logic             out_valid_q;
  logic             s1_adv;
  logic [WIDTH-1:0] or_y;
  logic [WIDTH:0]   add_sum, sub_sum;
  logic [4:0]       sh;
  logic             c, v;

  // S1 moves on whenever S2 is empty or being drained this cycle.
  assign s1_adv        = s1_valid && (!out_valid_q || bus.out_ready);
  assign bus.in_ready  = !s1_valid || s1_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = s2_q.y;
  assign bus.out_flags = s2_q.flags;
  assign bus.out_err   = s2_q.err;

  orrs_32bit u_orrs (.a(s1_q.a), .b(s1_q.b), .y(or_y));

  assign sh      = s1_q.b[4:0];
  assign add_sum = {1'b0, s1_q.a} + {1'b0, s1_q.b};
  // Carry-out of a + ~b + 1 is the "no borrow" indication.
  assign sub_sum = {1'b0, s1_q.a} + {1'b0, ~s1_q.b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    s2_d = '0;
    c    = 1'b0;
    v    = 1'b0;
    unique case (s1_q.op)
      OP_AND: s2_d.y = s1_q.a & s1_q.b;
      OP_OR:  s2_d.y = or_y;
      OP_XOR: s2_d.y = s1_q.a ^ s1_q.b;
      OP_ADD: begin
        s2_d.y = add_sum[WIDTH-1:0];
        c      = add_sum[WIDTH];
        v      = (s1_q.a[WIDTH-1] == s1_q.b[WIDTH-1]) && (add_sum[WIDTH-1] != s1_q.a[WIDTH-1]);
      end
      OP_SUB: begin
        s2_d.y = sub_sum[WIDTH-1:0];
        c      = sub_sum[WIDTH];
        v      = (s1_q.a[WIDTH-1] != s1_q.b[WIDTH-1]) && (sub_sum[WIDTH-1] != s1_q.a[WIDTH-1]);
      end
      OP_SLT: s2_d.y = {{(WIDTH-1){1'b0}}, ($signed(s1_q.a) < $signed(s1_q.b))};
      OP_SLL: s2_d.y = s1_q.a << sh;
      OP_SRL: s2_d.y = s1_q.a >> sh;
      OP_SRA: s2_d.y = WIDTH'($signed(s1_q.a) >>> sh);
      default: s2_d.err = 1'b1;
    endcase
    s2_d.flags = {s2_d.y[WIDTH-1], (s2_d.y == '0), c, v};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      s2_q        <= '0;
      op_count    <= '0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        s1_valid <= 1'b1;
        s1_q     <= '{op: bus.in_op, a: bus.in_a, b: bus.in_b};
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        out_valid_q <= 1'b1;
        s2_q        <= s2_d;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (out_valid_q && bus.out_ready) op_count <= op_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: driver pushes expected results, negedge monitor pops and checks.
`timescale 1ns/1ps
module tb_alu_exec_stage;
  typedef struct {
    logic [31:0] y;
    logic [3:0]  flags;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] op_count;

  alu_exec_stage_if #(.WIDTH(32)) bus ();
  alu_exec_stage #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .op_count(op_count));

  always #5 clk = ~clk;

  exp_t q[$];
  int   checks = 0, failures = 0;
  int   deliv = 0;
  int   rdy_mode = 0;
  bit   stall = 1'b0;
  exp_t held;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(logic [31:0] y, logic [3:0] flags, logic err);
    exp_t e;
    e.y = y; e.flags = flags; e.err = err;
    return e;
  endfunction

  // Reference: plain wide arithmetic on the operation definitions.
  function automatic exp_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    longint ua = longint'(a), ub = longint'(b);
    longint sa = longint'($signed(a)), sb = longint'($signed(b));
    longint s;
    int     sh = int'(b[4:0]);
    logic [31:0] y = 32'h0;
    logic c = 1'b0, v = 1'b0, err = 1'b0;
    case (op)
      4'd0: y = a & b;
      4'd1: y = a | b;
      4'd2: y = a ^ b;
      4'd3: begin
        s = ua + ub; y = s[31:0]; c = (s > 64'sh0FFFF_FFFF);
        s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd4: begin
        s = ua - ub; y = s[31:0]; c = (a >= b);
        s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd5: y = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: y = a << sh;
      4'd7: y = a >> sh;
      4'd8: begin s = sa >>> sh; y = s[31:0]; end
      default: err = 1'b1;
    endcase
    return mk(y, {y[31], (y == 32'h0), c, v}, err);
  endfunction

  // out_ready policy: 0 = held high, 1 = random, 2 = held low.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: all checks on the falling edge, where DUT outputs are settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        chk("in_ready", bus.in_ready, !(q.size() >= 2 && !bus.out_ready));
        chk("op_count", op_count, deliv & 32'hFFFF);
        if (q.size() == 0) chk("spurious_valid", bus.out_valid, 0);
        if (stall) begin
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_y", bus.out_y, held.y);
          chk("hold_flags", bus.out_flags, held.flags);
          chk("hold_err", bus.out_err, held.err);
        end
        if (bus.out_valid && bus.out_ready && q.size() != 0) begin
          e = q.pop_front();
          chk("y", bus.out_y, e.y);
          chk("flags", bus.out_flags, e.flags);
          chk("err", bus.out_err, e.err);
          deliv++;
        end
        stall = bus.out_valid && !bus.out_ready;
        held  = mk(bus.out_y, bus.out_flags, bus.out_err);
      end
    end
  end

  task automatic send(logic [3:0] op, logic [31:0] a, logic [31:0] b, exp_t e);
    bit done = 1'b0;
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_a = a; bus.in_b = b;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      if (done) q.push_back(e);
      #1;
    end
    bus.in_valid = 1'b0;
    // Scramble idle inputs: they must not be sampled.
    bus.in_op = 4'($urandom); bus.in_a = $urandom; bus.in_b = $urandom;
    chk("send_accepted", done, 1);
  endtask

  task automatic send_rand();
    logic [3:0]  op = 4'($urandom_range(0, 15));
    logic [31:0] a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
    logic [31:0] b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
    send(op, a, b, model(op, a, b));
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(posedge clk);
    chk("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; q.delete(); deliv = 0; stall = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_y", bus.out_y, 0);
    chk("rst_out_flags", bus.out_flags, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_op = 4'h0; bus.in_a = 32'h0; bus.in_b = 32'h0;
    rdy_mode = 0;
    apply_reset();

    // Basic OR with latency check.
    send(4'd1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, mk(32'hFFFF_FFFF, 4'b1000, 1'b0));
    @(negedge clk); chk("lat_s1_only", bus.out_valid, 0);
    @(negedge clk); chk("lat_s2_valid", bus.out_valid, 1);
    chk("lat_s2_y", bus.out_y, 32'hFFFF_FFFF);
    drain();
    chk("op_count_or", op_count, 1);

    // Arithmetic, shifts, SLT, illegal opcode back-to-back.
    send(4'd3, 32'h7FFF_FFFF, 32'h1,       mk(32'h8000_0000, 4'b1001, 1'b0));
    send(4'd3, 32'hFFFF_FFFF, 32'h1,       mk(32'h0,         4'b0110, 1'b0));
    send(4'd4, 32'd3,         32'd5,       mk(32'hFFFF_FFFE, 4'b1000, 1'b0));
    send(4'd8, 32'h8000_0000, 32'h24,      mk(32'hF800_0000, 4'b1000, 1'b0));
    send(4'd7, 32'h8000_0000, 32'h24,      mk(32'h0800_0000, 4'b0000, 1'b0));
    send(4'd5, 32'hFFFF_FFFF, 32'h1,       mk(32'h1,         4'b0000, 1'b0));
    send(4'd12, 32'h1234_5678, 32'h9ABC_DEF0, mk(32'h0,      4'b0100, 1'b1));
    drain();
    chk("op_count_directed", op_count, 8);

    // Backpressure: 8 random ops with random out_ready.
    apply_reset();
    rdy_mode = 1;
    repeat (8) send_rand();
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;
    chk("op_count_bp", op_count, 8);

    // Longer random run with gaps and random backpressure.
    rdy_mode = 1;
    repeat (60) begin
      send_rand();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    drain();
    rdy_mode = 0;
    repeat (2) @(posedge clk); #1;

    // Counter wrap.
    apply_reset();
    repeat (65535) send_rand();
    drain();
    chk("op_count_ffff", op_count, 16'hFFFF);
    send_rand();
    drain();
    chk("op_count_wrap", op_count, 0);

    // Reset mid-flight with both stages full.
    rdy_mode = 2;
    repeat (2) @(posedge clk); #2;
    send(4'd3, 32'd1, 32'd1, mk(32'd2, 4'b0000, 1'b0));
    send(4'd2, 32'hF0F0_F0F0, 32'h0F0F_0F0F, mk(32'hFFFF_FFFF, 4'b1000, 1'b0));
    @(negedge clk);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_out_valid", bus.out_valid, 1);
    chk("full_out_y", bus.out_y, 32'd2);
    #1 rst_n = 1'b0; q.delete(); deliv = 0; stall = 1'b0;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_y", bus.out_y, 0);
    chk("async_rst_op_count", op_count, 0);
    chk("async_rst_in_ready", bus.in_ready, 1);
    #2 rst_n = 1'b1;
    rdy_mode = 0;
    repeat (10) begin
      @(posedge clk); #1;
      chk("no_stale_valid", bus.out_valid, 0);
    end
    chk("no_stale_count", op_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered 32-bit ALU execute stage. It accepts operand/opcode requests over a valid/ready handshake, evaluates the selected operation through a two-register pipeline, and presents the result plus condition flags to the downstream writeback consumer. Bitwise OR is evaluated by the existing `orrs_32bit` unit, instantiated inside this stage. The other operations are evaluated locally.

## Interface
- `WIDTH`, default 32: operand/result width. Only 32 is supported; shift amounts use bits [4:0].
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  stage can accept a request this cycle.
- `in_op`  in  4  opcode: 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SLT (signed), 6 SLL, 7 SRL, 8 SRA; 9–15 illegal.
- `in_a`  in  32  operand A.
- `in_b`  in  32  operand B; bits [4:0] are the shift amount for SLL/SRL/SRA.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts the result.
- `out_y`  out  32  result.
- `out_flags`  out  4  {N, Z, C, V}.
- `out_err`  out  1  result came from an illegal opcode.
- `op_count`  out  16  count of results accepted downstream; wraps.

## Operation
- **Stage S1 (capture).** A transfer occurs when `in_valid && in_ready`. S1 then registers `in_op`, `in_a`, `in_b` and sets `s1_valid`.
- **Stage S2 (result).**
  - S2 evaluates S1's contents combinationally and registers `out_y`, `out_flags` and `out_err` when S1 advances.
  - `s1_adv = s1_valid && (!out_valid || out_ready)`.
  - `in_ready = !s1_valid || s1_adv` (full throughput; no combinational path from `in_valid`).
- **Arithmetic.**
  - ADD: 33-bit sum; C = bit 32.
  - SUB: `a + ~b + 1`; C = 1 when there is no borrow (`a >= b`, unsigned).
  - V is the signed overflow for ADD/SUB and 0 for every other op.
  - C = 0 for non-ADD/SUB ops.
- **Flags for all ops.** Z = (`out_y` == 0); N = `out_y[31]`.
- **SLT:** `out_y` = 1 if `$signed(a) < $signed(b)`, else 0.
- **Shifts.** SLL/SRL/SRA use `b[4:0]`; bits [31:5] of `b` are ignored.
- **Illegal opcode:** `out_y` = 0, flags = {0,1,0,0}, `out_err` = 1. The result is still delivered and handshaken normally.
- **Op counter.** `op_count` increments on each `out_valid && out_ready` and wraps from 0xFFFF to 0.
- **Output holding.**
  - `out_y`, `out_flags` and `out_err` hold stable while `out_valid && !out_ready`.
  - S1 holds while blocked.
  - No request is dropped or duplicated.

## Timing
- **Reset** (asynchronous assert, synchronous deassert at the next edge): `s1_valid`=0, `out_valid`=0, `out_y`=0, `out_flags`=0, `out_err`=0, `op_count`=0. `in_ready` reads 1 during and after reset.
- **Reset mid-operation:** all in-flight requests are discarded and none appear afterwards.
- **Latency:** a request accepted at edge k has `out_valid` high after edge k+1 when there is no backpressure.
- **Throughput:** one result per cycle with `out_ready` held high.
- **Backpressure with both stages full:** `in_ready`=0 until `out_ready` is high. In that cycle, S2 takes S1, S1 takes a new request if `in_valid`, and `in_ready`=1 in the same cycle.
- **Simultaneous events:**
  - Output drain and new S2 load on the same edge: `out_valid` stays 1 with the new data, and `op_count` increments by exactly 1.
  - S1 empty with S2 draining: `out_valid` falls to 0 on that edge.
- **Inputs:** `in_a`, `in_b` and `in_op` are sampled only on transfer edges; changes at other times have no effect.

## Test plan
- **Reset and basic ops.** After reset, check all outputs are 0. Send OR a=0xA5A5A5A5, b=0x5A5A5A5A; result appears 2 edges later with y=0xFFFFFFFF, N=1, Z=0, C=0, V=0, `op_count`=1.
- **Arithmetic flags.**
  - ADD 0x7FFFFFFF+1 → y=0x80000000, N=1, V=1, C=0.
  - ADD 0xFFFFFFFF+1 → y=0, Z=1, C=1, V=0.
  - SUB 3−5 → y=0xFFFFFFFE, N=1, C=0.
- **Shifts and SLT.**
  - SRA 0x80000000 by b=0x24 (amount 4) → 0xF8000000.
  - SRL same operands → 0x08000000.
  - SLT a=0xFFFFFFFF, b=1 → y=1.
- **Backpressure.** Stream 8 random ops with `out_ready` toggling pseudo-randomly. Check that results match a reference model in order, that outputs stay stable while stalled, that `in_ready` drops only when both stages are full, and that `op_count`=8.
- **Illegal opcode and counter wrap.**
  - op=12 → y=0, Z=1, `out_err`=1, delivered normally.
  - Preload 0xFFFF accepted transfers, then accept one more → `op_count`=0.
- **Reset mid-flight.** With both stages full and `out_ready`=0, pulse `rst_n` low for 3 ns (asynchronous, not aligned to `clk`). Outputs clear immediately, and no stale result appears after release.
